// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock period detector.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } det_state_t;

    localparam int LOCK_CNT_DEFAULT = 4;

endpackage : clk_div_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let meta and q update from the values held before the edge, forming a real two-stage chain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/clk_div_detector.sv
// Measures rise-to-rise period and high time of an asynchronous divided clock,
// flags lock after repeated equal periods and overflow when edges stop.
module clk_div_detector
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = LOCK_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    localparam int               MW         = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_CNT);

    det_state_t       state;
    logic             synced;
    logic             prev;
    logic             rise;
    logic             have_prev;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_next;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (div_in),
        .q     (synced)
    );

    assign rise = synced & ~prev;

    // A measurement only counts as a match when a previous period exists in this run.
    always_comb begin
        match_next = '0;
        if (have_prev && (pcnt == period)) begin
            match_next = (match_cnt == MATCH_FULL) ? match_cnt : match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            prev      <= 1'b0;
            have_prev <= 1'b0;
            pcnt      <= '0;
            hcnt      <= '0;
            match_cnt <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev  <= synced;
            valid <= 1'b0;
            case (state)
                IDLE, TIMEOUT: begin
                    if (rise) begin
                        state     <= MEASURE;
                        pcnt      <= CNT_W'(1);
                        hcnt      <= CNT_W'(1);
                        have_prev <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= pcnt;
                        high_time <= hcnt;
                        valid     <= 1'b1;
                        overflow  <= 1'b0;
                        match_cnt <= match_next;
                        locked    <= (match_next == MATCH_FULL);
                        have_prev <= 1'b1;
                        pcnt      <= CNT_W'(1);
                        hcnt      <= CNT_W'(1);
                    end else if (pcnt == CNT_MAX) begin
                        // No edge within the counter range: drop lock and wait for edges again.
                        state     <= TIMEOUT;
                        overflow  <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        have_prev <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                        hcnt <= hcnt + CNT_W'(synced);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : clk_div_detector
